// File: rtl/fetch_stage_bp.sv
// Instruction fetch stage with a direct-mapped BTB of 2-bit saturating counters.
// Drives imem from the PC, predicts next-PC, trains on EX resolution, redirects/squashes on mispredict.
module fetch_stage_bp #(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_correct_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_target
);
  localparam int          IDX  = $clog2(BTB_ENTRIES);
  localparam int          TAGW = 30 - IDX;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [31:0]     target;
    logic [1:0]      ctr;
  } btb_entry_t;

  btb_entry_t btb [BTB_ENTRIES];

  logic [31:0]     pc;
  logic [IDX-1:0]  l_idx, u_idx;
  btb_entry_t      l_ent, u_ent;
  logic            l_hit, u_hit, pred_taken;
  logic [31:0]     next_pc;
  logic            unused_lsbs;

  assign unused_lsbs = ^{ex_pc[1:0], ex_correct_pc[1:0]};

  assign imem_addr  = pc;
  assign l_idx      = pc[IDX+1:2];
  assign l_ent      = btb[l_idx];
  assign l_hit      = l_ent.valid && (l_ent.tag == pc[31:IDX+2]);
  assign pred_taken = l_hit && l_ent.ctr[1];
  assign next_pc    = pred_taken ? l_ent.target : pc + 32'd4;

  assign u_idx = ex_pc[IDX+1:2];
  assign u_ent = btb[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == ex_pc[31:IDX+2]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (ex_mispredict) begin
      pc <= {ex_correct_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc <= next_pc;
    end
  end

  // A redirect squashes IF/ID even while the hazard unit is stalling.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_instr       <= NOP;
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (ex_mispredict) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_instr       <= NOP;
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (!stall) begin
      id_valid       <= 1'b1;
      id_pc          <= pc;
      id_instr       <= imem_rdata;
      id_pred_taken  <= pred_taken;
      id_pred_target <= pred_taken ? l_ent.target : 32'h0;
    end
  end

  // Training ignores stall; lookup above always sees the pre-update entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (ex_update) begin
      if (u_hit) begin
        if (ex_taken) begin
          if (u_ent.ctr != 2'b11) btb[u_idx].ctr <= u_ent.ctr + 2'b01;
          btb[u_idx].target <= ex_target;
        end else if (u_ent.ctr != 2'b00) begin
          btb[u_idx].ctr <= u_ent.ctr - 2'b01;
        end
      end else if (ex_taken) begin
        btb[u_idx] <= '{valid: 1'b1, tag: ex_pc[31:IDX+2], target: ex_target, ctr: 2'b10};
      end
    end
  end

endmodule
